spu_ln_ctrl: RTL
================

# spu_ln_ctrl

Sequencer for the SPU LayerNorm datapath. It accepts a start command and a row/geometry configuration, then drives the datapath phase code, phase sub-counters and accumulate enable. It also generates read addresses into the activation buffer and write addresses into the output buffer, for one or more token rows back to back. It sits between the SPU instruction decoder and the LayerNorm datapath plus its two SRAMs.

## Interface
Parameters:
- ADDR_W, 12, buffer word-address width (one word = 4 x int8).
- WNUM_W, 10, width of per-row word count (max 512 words = 2048 channels).
- SQRT_TMO, 255, SQRT-phase cycle limit before timeout.

Ports:
- core_clk  in  1  clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- cfg_word_num  in  WNUM_W  words per row (N).
- cfg_row_num  in  8  rows to process (R).
- cfg_rd_base / cfg_wr_base  in  ADDR_W  base word addresses.
- cfg_shift_output  in  4, cfg_div_m  in  7, cfg_div_e  in  5  datapath scaling.
- sqrt_reci_finish  in  1  reciprocal-sqrt ready pulse from datapath.
- ln_state  out  3  phase code: IDLE 000, SUM_COUNT 001, SUM_DIV 011, SQRT 100, OUT 110.
- sum_div_cnt  out  1  SUM_DIV sub-cycle.
- sqrt_cnt  out  8  SQRT-phase cycle counter.
- sum_en  out  1  accumulate enable.
- ln_shift_output / ln_div_m / ln_div_e  out  4/7/5  latched config.
- buf_rd_en  out  1; buf_rd_addr  out  ADDR_W.
- buf_wr_en  out  1; buf_wr_addr  out  ADDR_W.
- busy  out  1; done  out  1 (pulse); err_tmo  out  1 (sticky until next start).

## Operation
- Reset: all outputs 0; ln_state = IDLE.
- IDLE: on start with N≠0 and R≠0, latch all cfg_* inputs, clear row index and err_tmo, set busy, and enter SUM_COUNT next cycle.
- start with N=0 or R=0: no state change; done pulses the next cycle; busy stays 0.
- start while busy is ignored. Config inputs are ignored outside the start cycle.
- SUM_COUNT lasts exactly N+2 cycles (local k = 0..N+1).
  - buf_rd_en=1 for k<N, with buf_rd_addr = rd_base + row*N + k.
  - SRAM read latency is 1 cycle; the datapath adds a 1-cycle register. sum_en=1 therefore for k = 2..N+1.
- SUM_DIV lasts 2 cycles: sum_div_cnt = 0 then 1.
- SQRT:
  - sqrt_cnt = 0 on the first cycle and increments each cycle, saturating at 255.
  - A sqrt_reci_finish sample of 1 while in SQRT moves to OUT next cycle.
  - If sqrt_cnt reaches SQRT_TMO without finish: set err_tmo, go to IDLE, pulse done, clear busy.
- OUT lasts N+1 cycles (k = 0..N).
  - buf_rd_en=1 for k<N, with the same addresses as SUM_COUNT.
  - buf_wr_en=1 for k≥1, with buf_wr_addr = wr_base + row*N + (k-1).
- End of OUT:
  - If row < R-1: increment row and enter SUM_COUNT directly, with no IDLE cycle.
  - Otherwise: go to IDLE, pulse done for 1 cycle, clear busy.
- Address arithmetic wraps modulo 2^ADDR_W.
- row*N is formed by an incremental row-base accumulator, not a multiplier.
- sum_div_cnt and sqrt_cnt are 0 outside their phases. sum_en is 0 outside SUM_COUNT.
- Reset asserted mid-operation returns all state to reset values immediately; no done pulse is produced.

## Timing
- All outputs are registered except the latched config outputs, which are held registers.
- Per-row latency is (N+2) + 2 + S + (N+1) cycles, where S is the number of SQRT cycles up to and including the finish sample.
- Command latency: start sampled at cycle 0 gives ln_state = SUM_COUNT at cycle 1.
- done is asserted in the first IDLE cycle after the last OUT cycle. busy falls in that same cycle.
- A new start is accepted in the cycle after done.

## Test plan
- N=1, R=1, rd_base=0x010, wr_base=0x200, finish 3 cycles into SQRT.
  - SUM_COUNT cycles 1-3: rd_en at cycle 1 (addr 0x010), sum_en at cycle 3.
  - SUM_DIV cycles 4-5. SQRT cycles 6-8, sqrt_cnt 0,1,2.
  - OUT cycles 9-10: rd at 9, wr at 10 (addr 0x200). done at cycle 11.
- N=4, R=2, rd_base=0xFFE: read addresses 0xFFE,0xFFF,0x000,0x001, then 0x002..0x005 for row 1 (wrap). OUT of row 0 is followed directly by SUM_COUNT with no IDLE cycle.
- start pulsed during SQRT, and again with different cfg during OUT: both ignored, and the original addresses and ln_div_m are kept.
- start with N=0 (and separately R=0): done one cycle later, ln_state stays IDLE, no rd/wr.
- sqrt_reci_finish never asserted: err_tmo=1 and done when sqrt_cnt=255, then IDLE. A subsequent valid start clears err_tmo.
- rst_n low at OUT k=2: all outputs 0 and IDLE asynchronously. A following start runs a full clean row.

Source files
------------

// File: rtl/spu_ln_ctrl.sv
// Phase sequencer for the SPU LayerNorm datapath: walks SUM_COUNT/SUM_DIV/SQRT/OUT
// per token row and generates activation-buffer read and output-buffer write addresses.
module spu_ln_ctrl #(
  parameter int ADDR_W   = 12,
  parameter int WNUM_W   = 10,
  parameter int SQRT_TMO = 255
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WNUM_W-1:0] cfg_word_num,
  input  logic [7:0]        cfg_row_num,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [3:0]        cfg_shift_output,
  input  logic [6:0]        cfg_div_m,
  input  logic [4:0]        cfg_div_e,
  input  logic              sqrt_reci_finish,
  output logic [2:0]        ln_state,
  output logic              sum_div_cnt,
  output logic [7:0]        sqrt_cnt,
  output logic              sum_en,
  output logic [3:0]        ln_shift_output,
  output logic [6:0]        ln_div_m,
  output logic [4:0]        ln_div_e,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err_tmo
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_SUM_COUNT = 3'b001,
    S_SUM_DIV   = 3'b011,
    S_SQRT      = 3'b100,
    S_OUT       = 3'b110
  } state_e;

  localparam int KW = WNUM_W + 1;
  localparam logic [7:0] TMO = 8'(SQRT_TMO);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [7:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [WNUM_W-1:0] n_q, n_d;
  logic [7:0]        r_q, r_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic [3:0]        shift_q, shift_d;
  logic [6:0]        div_m_q, div_m_d;
  logic [4:0]        div_e_q, div_e_d;
  logic              sum_div_cnt_q, sum_div_cnt_d;
  logic [7:0]        sqrt_cnt_q, sqrt_cnt_d;
  logic              sum_en_q, sum_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [KW-1:0]     n_ext;
  logic [ADDR_W-1:0] k_addr;

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      row_q         <= '0;
      row_base_q    <= '0;
      n_q           <= '0;
      r_q           <= '0;
      rd_base_q     <= '0;
      wr_base_q     <= '0;
      shift_q       <= '0;
      div_m_q       <= '0;
      div_e_q       <= '0;
      sum_div_cnt_q <= 1'b0;
      sqrt_cnt_q    <= '0;
      sum_en_q      <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      row_q         <= row_d;
      row_base_q    <= row_base_d;
      n_q           <= n_d;
      r_q           <= r_d;
      rd_base_q     <= rd_base_d;
      wr_base_q     <= wr_base_d;
      shift_q       <= shift_d;
      div_m_q       <= div_m_d;
      div_e_q       <= div_e_d;
      sum_div_cnt_q <= sum_div_cnt_d;
      sqrt_cnt_q    <= sqrt_cnt_d;
      sum_en_q      <= sum_en_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    n_d        = n_q;
    r_d        = r_q;
    rd_base_d  = rd_base_q;
    wr_base_d  = wr_base_q;
    shift_d    = shift_q;
    div_m_d    = div_m_q;
    div_e_d    = div_e_q;
    err_d      = err_q;
    done_d     = 1'b0;
    n_ext      = {1'b0, n_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_word_num != '0 && cfg_row_num != '0) begin
            n_d        = cfg_word_num;
            r_d        = cfg_row_num;
            rd_base_d  = cfg_rd_base;
            wr_base_d  = cfg_wr_base;
            shift_d    = cfg_shift_output;
            div_m_d    = cfg_div_m;
            div_e_d    = cfg_div_e;
            state_d    = S_SUM_COUNT;
            k_d        = '0;
            row_d      = '0;
            row_base_d = '0;
            err_d      = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SUM_COUNT: begin
        // Two extra cycles drain the SRAM read and the datapath input register.
        if (k_q == n_ext + KW'(1)) begin
          state_d = S_SUM_DIV;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_SUM_DIV: begin
        if (sum_div_cnt_q) state_d = S_SQRT;
      end
      S_SQRT: begin
        if (sqrt_reci_finish) begin
          state_d = S_OUT;
          k_d     = '0;
        end else if (sqrt_cnt_q == TMO) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      S_OUT: begin
        if (k_q == n_ext) begin
          if ({1'b0, row_q} + 9'd1 < {1'b0, r_q}) begin
            row_d      = row_q + 8'd1;
            row_base_d = row_base_q + ADDR_W'(n_q);
            state_d    = S_SUM_COUNT;
            k_d        = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered outputs are decoded from the next-state values so they align with ln_state.
    k_addr        = ADDR_W'(k_d);
    sum_div_cnt_d = (state_d == S_SUM_DIV) && (state_q == S_SUM_DIV);
    sqrt_cnt_d    = '0;
    if (state_d == S_SQRT && state_q == S_SQRT)
      sqrt_cnt_d = (sqrt_cnt_q == 8'hFF) ? 8'hFF : sqrt_cnt_q + 8'd1;
    sum_en_d  = (state_d == S_SUM_COUNT) && (k_d >= KW'(2));
    rd_en_d   = (state_d == S_SUM_COUNT || state_d == S_OUT) && (k_d < {1'b0, n_d});
    rd_addr_d = rd_en_d ? rd_base_d + row_base_d + k_addr : '0;
    wr_en_d   = (state_d == S_OUT) && (k_d != '0);
    wr_addr_d = wr_en_d ? wr_base_d + row_base_d + k_addr - ADDR_W'(1) : '0;
    busy_d    = (state_d != S_IDLE);
  end

  assign ln_state        = state_q;
  assign sum_div_cnt     = sum_div_cnt_q;
  assign sqrt_cnt        = sqrt_cnt_q;
  assign sum_en          = sum_en_q;
  assign ln_shift_output = shift_q;
  assign ln_div_m        = div_m_q;
  assign ln_div_e        = div_e_q;
  assign buf_rd_en       = rd_en_q;
  assign buf_rd_addr     = rd_addr_q;
  assign buf_wr_en       = wr_en_q;
  assign buf_wr_addr     = wr_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_tmo         = err_q;

endmodule
